// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (instruction / data) single-port RAM arbiter with
//            data priority and a starvation guard for instruction fetches.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    // instruction port
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // data port
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    // grant status
    output logic [1:0]  gnt
);

    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] IGNT = 2'b01;
    localparam logic [1:0] DGNT = 2'b10;

    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1_BAD1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic        d_req;
    logic        ram_done;
    logic        starving;
    logic        i_fin;
    logic        d_fin;
    logic [31:0] load_val;

    assign d_req    = dREN | dWEN;
    assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    assign starving = iREN && (starve_cnt_q >= LIMIT_C);
    // a transaction only completes while its requester is still asking
    assign i_fin    = (state_q == IGNT) && iREN  && ram_done;
    assign d_fin    = (state_q == DGNT) && d_req && ram_done;
    assign load_val = (ramstate == RAM_ERROR) ? ERR_WORD : ramload;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && !starving) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                if (!iREN || i_fin) begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                if (!d_req || d_fin) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!iREN || i_fin) begin
            starve_cnt_d = '0;
        end else if (d_fin && (starve_cnt_q < LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // reset drives state_q to IDLE asynchronously, which zeroes every RAM-side output
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iload    = 32'd0;
        dload    = 32'd0;
        case (state_q)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = load_val;
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = load_val;
            end
            default: ;
        endcase
    end

    assign gnt   = state_q;
    assign iwait = iREN  & ~i_fin;
    assign dwait = d_req & ~d_fin;

endmodule

`default_nettype wire
